// File: rtl/arm_pkg.sv
// Shared definitions for the ARM execute stage: execute-command codes, NZCV bit positions, default widths.
// Latency: n/a (package only).
// Backpressure: n/a.
package arm_pkg;

  localparam int ARM_WIDTH      = 32;
  localparam int ARM_REG_ADDR_W = 4;

  // Execute-command codes driven by the decode-stage controller
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;
  localparam logic [3:0] EXE_CMP = 4'b1100;
  localparam logic [3:0] EXE_TST = 4'b1110;

  // Bit positions inside the 4-bit NZCV word
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/arm_alu.sv
// Combinational ALU: result, candidate NZCV flags and a per-flag write mask for the selected command.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the enclosing stage decides whether the flags are committed.
module arm_alu
  import arm_pkg::*;
#(
  parameter int WIDTH = ARM_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       cmd,
  input  logic             c_in,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       nzcv,
  output logic [3:0]       flag_we
);

  logic [WIDTH:0] add_sum;
  logic [WIDTH:0] sub_sum;
  logic           add_cin;
  logic           sub_cin;
  logic           add_v;
  logic           sub_v;
  logic           c_flag;
  logic           v_flag;

  // Subtraction is a + ~b + carry so bit WIDTH is directly the ARM "not borrow" carry.
  // SBC folds its -(~C) term into that carry-in, which is just the registered C.
  assign add_cin = (cmd == EXE_ADC) ? c_in : 1'b0;
  assign sub_cin = (cmd == EXE_SBC) ? c_in : 1'b1;
  assign add_sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, add_cin};
  assign sub_sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, sub_cin};

  assign add_v = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
  assign sub_v = (a[WIDTH-1] != b[WIDTH-1]) && (sub_sum[WIDTH-1] != a[WIDTH-1]);

  // Operation select; logical ops only enable N/Z, unknown codes enable nothing
  always_comb begin
    result  = '0;
    c_flag  = 1'b0;
    v_flag  = 1'b0;
    flag_we = 4'b0000;
    case (cmd)
      EXE_MOV: begin
        result          = b;
        flag_we[FLAG_N] = 1'b1;
        flag_we[FLAG_Z] = 1'b1;
      end
      EXE_MVN: begin
        result          = ~b;
        flag_we[FLAG_N] = 1'b1;
        flag_we[FLAG_Z] = 1'b1;
      end
      EXE_ADD, EXE_ADC: begin
        result  = add_sum[WIDTH-1:0];
        c_flag  = add_sum[WIDTH];
        v_flag  = add_v;
        flag_we = 4'b1111;
      end
      EXE_SUB, EXE_SBC, EXE_CMP: begin
        result  = sub_sum[WIDTH-1:0];
        c_flag  = sub_sum[WIDTH];
        v_flag  = sub_v;
        flag_we = 4'b1111;
      end
      EXE_AND, EXE_TST: begin
        result          = a & b;
        flag_we[FLAG_N] = 1'b1;
        flag_we[FLAG_Z] = 1'b1;
      end
      EXE_ORR: begin
        result          = a | b;
        flag_we[FLAG_N] = 1'b1;
        flag_we[FLAG_Z] = 1'b1;
      end
      EXE_EOR: begin
        result          = a ^ b;
        flag_we[FLAG_N] = 1'b1;
        flag_we[FLAG_Z] = 1'b1;
      end
      default: begin
        result  = '0;
        flag_we = 4'b0000;
      end
    endcase
  end

  // Pack the candidate flag word
  always_comb begin
    nzcv         = 4'b0000;
    nzcv[FLAG_N] = result[WIDTH-1];
    nzcv[FLAG_Z] = (result == '0);
    nzcv[FLAG_C] = c_flag;
    nzcv[FLAG_V] = v_flag;
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: ALU, branch target, NZCV status register and EX/MEM register (EXE_FWD_EN adds operand forwarding muxes).
// Latency: ALU result and controls 1 cycle to EX/MEM outputs; branch_taken/branch_address combinational.
// Backpressure: freeze holds EX/MEM and status; flush loads a bubble and wins over freeze.
module exe_stage
  import arm_pkg::*;
#(
  parameter int WIDTH      = ARM_WIDTH,
  parameter int REG_ADDR_W = ARM_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic [3:0]            exe_cmd,
  input  logic                  wb_en_in,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic                  s_in,
  input  logic                  branch_taken_in,
  input  logic [WIDTH-1:0]      pc_in,
  input  logic [WIDTH-1:0]      val_rn,
  input  logic [WIDTH-1:0]      val2,
  input  logic [WIDTH-1:0]      val_rm,
  input  logic [23:0]           imm24,
  input  logic [REG_ADDR_W-1:0] dest_in,
`ifdef EXE_FWD_EN
  input  logic [1:0]            sel_src1,
  input  logic [1:0]            sel_src2,
  input  logic [WIDTH-1:0]      fwd_mem_val,
  input  logic [WIDTH-1:0]      fwd_wb_val,
`endif
  output logic [3:0]            status_out,
  output logic                  branch_taken,
  output logic [WIDTH-1:0]      branch_address,
  output logic [WIDTH-1:0]      alu_result,
  output logic [WIDTH-1:0]      st_val,
  output logic [REG_ADDR_W-1:0] dest,
  output logic                  wb_en,
  output logic                  mem_read,
  output logic                  mem_write
);

  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic [WIDTH-1:0] store_data;
  logic [WIDTH-1:0] alu_out;
  logic [3:0]       alu_nzcv;
  logic [3:0]       alu_flag_we;
  logic [3:0]       status_q;
  logic [WIDTH-1:0] imm_ext;

`ifdef EXE_FWD_EN
  // Operand forwarding: 01 takes the MEM-stage result, 10 the WB value, anything else the ID/EX value
  always_comb begin
    src1 = val_rn;
    src2 = val2;
    case (sel_src1)
      2'b01:   src1 = fwd_mem_val;
      2'b10:   src1 = fwd_wb_val;
      default: src1 = val_rn;
    endcase
    case (sel_src2)
      2'b01:   src2 = fwd_mem_val;
      2'b10:   src2 = fwd_wb_val;
      default: src2 = val2;
    endcase
  end
  // A store whose data register is being forwarded must pick up the forwarded value too
  assign store_data = (sel_src2 == 2'b00) ? val_rm : src2;
`else
  assign src1       = val_rn;
  assign src2       = val2;
  assign store_data = val_rm;
`endif

  arm_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a       (src1),
    .b       (src2),
    .cmd     (exe_cmd),
    .c_in    (status_q[FLAG_C]),
    .result  (alu_out),
    .nzcv    (alu_nzcv),
    .flag_we (alu_flag_we)
  );

  // Branch target: PC+4 plus word-scaled signed offset, wrapping at WIDTH bits
  assign imm_ext        = {{(WIDTH-24){imm24[23]}}, imm24};
  assign branch_address = pc_in + (imm_ext << 2);
  assign branch_taken   = branch_taken_in;
  assign status_out     = status_q;

  // Status register: commit only the flags the command defines, and never while stalled or flushed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q <= 4'b0000;
    end else if (s_in && !freeze && !flush) begin
      status_q <= (status_q & ~alu_flag_we) | (alu_nzcv & alu_flag_we);
    end
  end

  // EX/MEM register: flush inserts an all-zero bubble, freeze holds, otherwise load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_result <= '0;
      st_val     <= '0;
      dest       <= '0;
      wb_en      <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
    end else if (flush) begin
      alu_result <= '0;
      st_val     <= '0;
      dest       <= '0;
      wb_en      <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
    end else if (!freeze) begin
      alu_result <= alu_out;
      st_val     <= store_data;
      dest       <= dest_in;
      wb_en      <= wb_en_in;
      mem_read   <= mem_read_in;
      mem_write  <= mem_write_in;
    end
  end

endmodule
